rv32_cpu_cp_sched: RTL and testbench

//  Sequencer/arbiter between CPU control and the ALU co-processor slots
//  (0 shift, 1 mul, 2 div, 3-4 reserved). Accepts one request at a time and

---
 rtl/rv32_cpu_pkg.sv | 30 +++
 rtl/rv32_cpu_cp_sched.sv | 138 +++++++++++++
 tb/tb_rv32_cpu_cp_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rv32_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_cpu_pkg
// Description : Shared co-processor slot indices, scheduler state encoding and
//               the timeout counter width helper.
// Revision    : 1.0
// ============================================================================
package rv32_cpu_pkg;

    localparam int CP_SHIFT = 0;
    localparam int CP_MUL   = 1;
    localparam int CP_DIV   = 2;

    localparam int STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } cp_state_e;

    // Counter only needs to hold TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_cpu_cp_sched.sv
`default_nettype none
// ============================================================================
// Module      : rv32_cpu_cp_sched
// Description : Single-outstanding request sequencer between CPU control and
//               the ALU co-processor slots, with timeout and trap abort.
// Revision    : 1.0
// ============================================================================
module rv32_cpu_cp_sched
    import rv32_cpu_pkg::*;
#(
    parameter int                XLEN       = 32,
    parameter int                NUM_CP     = 5,
    parameter logic [NUM_CP-1:0] CP_EN_MASK = 5'b00111,
    parameter int                TIMEOUT    = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_trap,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [2:0]             i_req_sel,
    input  logic [2:0]             i_req_funct3,
    input  logic [XLEN-1:0]        i_req_rs1,
    input  logic [XLEN-1:0]        i_req_rs2,
    output logic [NUM_CP-1:0]      o_cp_start,
    output logic [2:0]             o_cp_funct3,
    output logic [XLEN-1:0]        o_cp_rs1,
    output logic [XLEN-1:0]        o_cp_rs2,
    input  logic [NUM_CP-1:0]      i_cp_valid,
    input  logic [NUM_CP*XLEN-1:0] i_cp_res,
    output logic                   o_done,
    output logic                   o_err,
    output logic [XLEN-1:0]        o_res,
    output logic                   o_busy
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    cp_state_e         r_state;
    cp_state_e         w_state_nxt;
    logic [2:0]        r_sel;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic              r_bad;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_res;
    logic              w_accept;
    logic              w_sel_ok;
    logic              w_hit;
    logic [XLEN-1:0]   w_sel_res;

    assign w_accept  = i_req_valid && (r_state == ST_IDLE);
    assign w_hit     = i_cp_valid[r_sel];
    assign w_sel_res = i_cp_res[int'(r_sel)*XLEN +: XLEN];

    // Slot indices beyond NUM_CP never match, so they are treated as disabled.
    always_comb begin
        w_sel_ok = 1'b0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (i_req_sel == i[2:0] && CP_EN_MASK[i]) begin
                w_sel_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Disabled slots still pass through START (without a pulse) before ERR.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !i_trap) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (i_trap)      w_state_nxt = ST_IDLE;
                else if (r_bad)  w_state_nxt = ST_ERR;
                else             w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_trap)               w_state_nxt = ST_IDLE;
                else if (w_hit)           w_state_nxt = ST_DONE;
                else if (r_cnt == '0)     w_state_nxt = ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel    <= '0;
            r_funct3 <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_bad    <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= i_req_sel;
                r_funct3 <= i_req_funct3;
                r_rs1    <= i_req_rs1;
                r_rs2    <= i_req_rs2;
                r_bad    <= !w_sel_ok;
            end
            if (r_state == ST_START) begin
                r_cnt <= CNT_W'(TIMEOUT - 1);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_state_nxt == ST_DONE) begin
                r_res <= w_sel_res;
            end else if (w_state_nxt == ST_ERR) begin
                r_res <= '0;
            end
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign o_err       = (r_state == ST_ERR);
    assign o_res       = r_res;
    assign o_cp_funct3 = r_funct3;
    assign o_cp_rs1    = r_rs1;
    assign o_cp_rs2    = r_rs2;
    assign o_cp_start  = (r_state == ST_START && !r_bad && !i_trap && !i_rst)
                       ? ({{(NUM_CP-1){1'b0}}, 1'b1} << r_sel) : '0;

endmodule
`default_nettype wire

// File: tb/tb_rv32_cpu_cp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_cpu_cp_sched
// Description : Randomized self-checking bench for rv32_cpu_cp_sched against a
//               per-transaction outcome model.
// Revision    : 1.0
// ============================================================================
module tb_rv32_cpu_cp_sched;

    localparam int XLEN = 32;
    localparam int NCP  = 5;
    localparam int TMO  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               trap = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [2:0]         req_sel = '0;
    logic [2:0]         req_funct3 = '0;
    logic [XLEN-1:0]    req_rs1 = '0;
    logic [XLEN-1:0]    req_rs2 = '0;
    logic [NCP-1:0]     cp_start;
    logic [2:0]         cp_funct3;
    logic [XLEN-1:0]    cp_rs1;
    logic [XLEN-1:0]    cp_rs2;
    logic [NCP-1:0]     cp_valid = '0;
    logic [NCP*XLEN-1:0] cp_res = '0;
    logic               done;
    logic               err;
    logic [XLEN-1:0]    res;
    logic               busy;

    logic [NCP-1:0]     c_mask = 5'b00111;
    int                 n_checks = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    rv32_cpu_cp_sched #(
        .XLEN       (XLEN),
        .NUM_CP     (NCP),
        .CP_EN_MASK (5'b00111),
        .TIMEOUT    (TMO)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_trap       (trap),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_sel    (req_sel),
        .i_req_funct3 (req_funct3),
        .i_req_rs1    (req_rs1),
        .i_req_rs2    (req_rs2),
        .o_cp_start   (cp_start),
        .o_cp_funct3  (cp_funct3),
        .o_cp_rs1     (cp_rs1),
        .o_cp_rs2     (cp_rs2),
        .i_cp_valid   (cp_valid),
        .i_cp_res     (cp_res),
        .o_done       (done),
        .o_err        (err),
        .o_res        (res),
        .o_busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic randomize_slots(input bit stray, input logic [2:0] sel);
        for (int i = 0; i < NCP; i++) begin
            cp_res[i*XLEN +: XLEN] = $urandom;
        end
        cp_valid = stray ? NCP'($urandom) : '0;
        if (sel < NCP) cp_valid[sel] = 1'b0;
    endtask

    // k: selected slot raises valid in cycle 1+k (0 = never).
    // trap_at: cycle of i_trap relative to accept (-1 = none, 0 = same as accept).
    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rv, input int k, input int trap_at, input bit stray);
        logic [2:0]     f;
        logic [NCP-1:0] oh;
        bit             en, e, dropped, aborted;
        int             d, last;
        f  = 3'($urandom);
        en = (sel < NCP) ? c_mask[sel] : 1'b0;
        oh = en ? (NCP'(1) << sel) : '0;
        if (!en) begin
            d = 2; e = 1'b1;
        end else if (k >= 1 && k <= TMO) begin
            d = 2 + k; e = 1'b0;
        end else begin
            d = TMO + 2; e = 1'b1;
        end
        dropped = (trap_at == 0);
        aborted = dropped || (trap_at >= 1 && trap_at < d);
        last    = dropped ? 0 : (aborted ? trap_at : d);

        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = sel; req_funct3 = f; req_rs1 = a; req_rs2 = b;
        trap = (trap_at == 0);
        randomize_slots(stray, sel);
        @(negedge clk);
        check_eq("accept_ready", 32'(req_ready), 32'd1);

        for (int c = 1; c <= TMO + 3; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_rs1   = $urandom;
            req_rs2   = $urandom;
            trap      = (c == trap_at);
            randomize_slots(stray, sel);
            if (en && k >= 1 && c == 1 + k) begin
                cp_valid[sel] = 1'b1;
                cp_res[int'(sel)*XLEN +: XLEN] = rv;
            end
            @(negedge clk);
            check_eq("busy",  32'(busy),      32'(c <= last));
            check_eq("ready", 32'(req_ready), 32'(c > last));
            check_eq("start", 32'(cp_start),
                     32'((c == 1 && !dropped && trap_at != 1) ? oh : '0));
            check_eq("done",  32'(done), 32'(!aborted && c == d));
            check_eq("err",   32'(err),  32'(!aborted && c == d && e));
            if (!aborted && c == d) check_eq("res", res, e ? 32'd0 : rv);
            if (c == 1 && !dropped) begin
                check_eq("rs1", cp_rs1, a);
                check_eq("rs2", cp_rs2, b);
                check_eq("funct3", 32'(cp_funct3), 32'(f));
            end
        end
        trap = 1'b0;
        cp_valid = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_start"}, 32'(cp_start), 32'd0);
        check_eq({tag, "_done"},  32'(done),     32'd0);
        check_eq({tag, "_err"},   32'(err),      32'd0);
        check_eq({tag, "_busy"},  32'(busy),     32'd0);
        check_eq({tag, "_ready"}, 32'(req_ready),32'd1);
        check_eq({tag, "_res"},   res,           32'd0);
        check_eq({tag, "_rs1"},   cp_rs1,        32'd0);
        check_eq({tag, "_rs2"},   cp_rs2,        32'd0);
        check_eq({tag, "_f3"},    32'(cp_funct3),32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        run_op(3'd1, 32'd7, 32'd6, 32'd42, 3, -1, 1'b0);
        run_op(3'd3, $urandom, $urandom, $urandom, 2, -1, 1'b0);
        run_op(3'd6, $urandom, $urandom, $urandom, 2, -1, 1'b1);
        run_op(3'd2, $urandom, $urandom, $urandom, 0, -1, 1'b0);
        run_op(3'd0, $urandom, $urandom, 32'd5, 4, -1, 1'b1);
        run_op(3'd2, $urandom, $urandom, $urandom, 3, 4, 1'b0);
        run_op(3'd1, $urandom, $urandom, $urandom, 2, 1, 1'b0);
        run_op(3'd1, $urandom, $urandom, $urandom, 2, 0, 1'b0);
        run_op(3'd2, $urandom, $urandom, $urandom, TMO, -1, 1'b1);
        run_op(3'd0, $urandom, $urandom, $urandom, 1, -1, 1'b1);

        // Reset in the middle of WAIT.
        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = 3'd1; req_rs1 = 32'h1234; req_rs2 = 32'h5678; req_funct3 = 3'd5;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        run_op(3'd1, $urandom, $urandom, $urandom, 2, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] s;
            int         kk, tt;
            s  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            kk = $urandom_range(0, TMO + 2);
            tt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2) : -1;
            run_op(s, $urandom, $urandom, $urandom, kk, tt, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
